// File: rtl/fp2fix_pipe_if.sv
// fp2fix_pipe_if -- handshake bundle for the float-to-Q3.25 converter.
//   in_valid/in_ready/dataa        : upstream operand channel (IEEE-754 single)
//   out_valid/out_ready            : downstream result channel
//   fixed_out/ovf/nan              : Q3.25 result and its status flags
// master = environment driving operands and consuming results; slave = converter.
interface fp2fix_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dataa;
  logic        out_valid;
  logic        out_ready;
  logic [27:0] fixed_out;
  logic        ovf;
  logic        nan;

  modport master (
    output in_valid, dataa, out_ready,
    input  in_ready, out_valid, fixed_out, ovf, nan
  );

  modport slave (
    input  in_valid, dataa, out_ready,
    output in_ready, out_valid, fixed_out, ovf, nan
  );
endinterface

// File: rtl/fp2fix_pipe.sv
// fp2fix_pipe -- 3-stage IEEE-754 single to signed Q3.25 converter.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset, clears every stage
//   bus : fp2fix_pipe_if.slave (operand in, Q3.25 result + ovf/nan out)
// Stages: S1 unpack/classify, S2 magnitude shift, S3 sign apply/saturate.
// One global advance freezes the whole pipe while the output is stalled.
module fp2fix_pipe (
  input  logic         clk,
  input  logic         rst,
  fp2fix_pipe_if.slave bus
);
  localparam int STAGES = 3;

  typedef struct packed {
    logic        sign;
    logic [7:0]  e;
    logic [23:0] m;
    logic        nan;
    logic        sat;
  } s1_t;

  typedef struct packed {
    logic        sign;
    logic [26:0] mag;
    logic        nan;
    logic        sat;
  } s2_t;

  typedef struct packed {
    logic [27:0] fx;
    logic        ovf;
    logic        nan;
  } s3_t;

  logic [STAGES:1] vld_pipe;
  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  s3_t s3_d, s3_q;
  logic advance, fire;
  logic [7:0] up_sh, dn_sh;

  assign advance      = !vld_pipe[STAGES] | bus.out_ready;
  assign bus.in_ready = advance;
  assign fire         = bus.in_valid & advance;

  // S1: unpack. Exponent 0 (zero/denormal) forces a zero magnitude; any
  // exponent >= 129 that is not NaN (incl. infinity) saturates.
  always_comb begin
    s1_d      = '0;
    s1_d.sign = bus.dataa[31];
    s1_d.e    = bus.dataa[30:23];
    s1_d.m    = (bus.dataa[30:23] == 8'd0) ? 24'd0 : {1'b1, bus.dataa[22:0]};
    s1_d.nan  = (bus.dataa[30:23] == 8'hFF) && (bus.dataa[22:0] != 23'd0);
    s1_d.sat  = (bus.dataa[30:23] >= 8'd129) && !s1_d.nan;
  end

  // S2: value * 2^25 = m * 2^(e-125). Left shift covers e in 125..128;
  // saturating exponents take the same path but are overridden in S3.
  assign up_sh = s1_q.e - 8'd125;
  assign dn_sh = 8'd125 - s1_q.e;

  always_comb begin
    s2_d      = '0;
    s2_d.sign = s1_q.sign;
    s2_d.nan  = s1_q.nan;
    s2_d.sat  = s1_q.sat;
    if (s1_q.e >= 8'd125)
      s2_d.mag = {3'b000, s1_q.m} << up_sh[1:0];
    else if (dn_sh >= 8'd24)
      s2_d.mag = '0;
    else
      s2_d.mag = {3'b000, s1_q.m} >> dn_sh[4:0];
  end

  // S3: NaN wins over saturation so the flags stay mutually exclusive.
  always_comb begin
    s3_d = '0;
    if (s2_q.nan) begin
      s3_d.nan = 1'b1;
    end else if (s2_q.sat) begin
      s3_d.ovf = 1'b1;
      s3_d.fx  = s2_q.sign ? 28'h8000000 : 28'h7FFFFFF;
    end else begin
      s3_d.fx  = s2_q.sign ? (28'd0 - {1'b0, s2_q.mag}) : {1'b0, s2_q.mag};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      s3_q     <= '0;
    end else if (advance) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], fire};
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
    end
  end

  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.fixed_out = s3_q.fx;
  assign bus.ovf       = s3_q.ovf;
  assign bus.nan       = s3_q.nan;
endmodule

// File: tb/tb_fp2fix_pipe.sv
module tb_fp2fix_pipe;
  logic clk = 1'b0;
  logic rst = 1'b0;
  fp2fix_pipe_if bus();

  fp2fix_pipe dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] v;   // {ovf, nan, fixed}
    int          pc;  // cycle of acceptance
    int          ps;  // stall count at acceptance
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          stalls  = 0;
  logic        stall_prev = 1'b0;
  logic [29:0] held;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic real pow2(input int n);
    real r = 1.0;
    if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
    else        for (int i = 0; i < -n; i++) r = r * 0.5;
    return r;
  endfunction

  // Reference: decode to a real value, saturate when |x| >= 4, else scale by
  // 2^25 and truncate toward zero.
  function automatic logic [29:0] model(input logic [31:0] w);
    int   e;
    real  r;
    int   v;
    logic [27:0] fx;
    e = int'(w[30:23]);
    if (e == 255 && w[22:0] != 23'd0) return {2'b01, 28'h0};
    if (e == 0) return '0;
    r = real'({1'b1, w[22:0]}) * pow2(e - 150);
    if (r >= 4.0) return {2'b10, (w[31] ? 28'h8000000 : 28'h7FFFFFF)};
    v = $rtoi(r * 33554432.0);
    if (w[31]) v = -v;
    fx = 28'(v);
    return {2'b00, fx};
  endfunction

  task automatic cycle(input logic iv, input logic [31:0] d, input logic ordy,
                       input logic use_x, input logic [29:0] xv);
    exp_t h;
    @(negedge clk);
    cyc++;
    if (stall_prev) begin
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_out", {bus.ovf, bus.nan, bus.fixed_out}, held);
    end
    bus.in_valid  = iv;
    bus.dataa     = d;
    bus.out_ready = ordy;
    #1;
    chk("in_ready", bus.in_ready, (!bus.out_valid || ordy));
    if (bus.out_valid) begin
      chk("flag_excl", bus.ovf & bus.nan, 0);
      if (exp_q.size() == 0) begin
        chk("spurious_valid", bus.out_valid, 0);
      end else begin
        h = exp_q[0];
        chk("conv", {bus.ovf, bus.nan, bus.fixed_out}, h.v);
        if (ordy) begin
          chk("latency", cyc - h.pc, 3 + stalls - h.ps);
          void'(exp_q.pop_front());
        end
      end
    end
    stall_prev = bus.out_valid && !ordy;
    held       = {bus.ovf, bus.nan, bus.fixed_out};
    if (stall_prev) stalls++;
    if (iv && bus.in_ready) begin
      h.v  = use_x ? xv : model(d);
      h.pc = cyc;
      h.ps = stalls;
      exp_q.push_back(h);
    end
  endtask

  task automatic push(input logic [31:0] d);
    cycle(1'b1, d, 1'b1, 1'b0, '0);
  endtask

  task automatic pushx(input logic [31:0] d, input logic [29:0] x);
    cycle(1'b1, d, 1'b1, 1'b1, x);
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) cycle(1'b0, '0, 1'b1, 1'b0, '0);
    chk("drain_empty", exp_q.size(), 0);
    for (int i = 0; i < 2; i++) cycle(1'b0, '0, 1'b1, 1'b0, '0);
  endtask

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    case ($urandom_range(0, 3))
      0: w = $urandom;
      1: w = {1'($urandom), 8'($urandom_range(95, 131)), 23'($urandom)};
      2: w = {1'($urandom), 8'($urandom_range(122, 129)), 23'($urandom)};
      default: begin
        case ($urandom_range(0, 4))
          0: w = {1'($urandom), 31'h7F800000};
          1: w = {1'($urandom), 8'hFF, 23'($urandom_range(1, 8388607))};
          2: w = {1'($urandom), 8'h00, 23'($urandom)};
          3: w = {1'($urandom), 8'($urandom_range(100, 102)), 23'($urandom)};
          default: w = {1'($urandom), 8'd128, 23'h7FFFFF};
        endcase
      end
    endcase
    return w;
  endfunction

  initial begin
    bus.in_valid  = 1'b0;
    bus.dataa     = '0;
    bus.out_ready = 1'b1;

    // reset state
    #3;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_out", {bus.ovf, bus.nan, bus.fixed_out}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // basic conversion, back to back
    pushx(32'h3F060A92, {2'b00, 28'h10C1524});
    pushx(32'h3E860A92, {2'b00, 28'h0860A92});
    pushx(32'hBF060A92, {2'b00, 28'hEF3EADC});
    drain();

    // special values and underflow
    pushx(32'h40800000, {2'b10, 28'h7FFFFFF});
    pushx(32'hFF800000, {2'b10, 28'h8000000});
    pushx(32'h7FC00000, {2'b01, 28'h0000000});
    pushx(32'h00000001, {2'b00, 28'h0000000});
    pushx(32'h80000000, {2'b00, 28'h0000000});
    pushx(32'h33000000, {2'b00, 28'h0000001});
    pushx(32'h32800000, {2'b00, 28'h0000000});
    pushx(32'hC07FFFFF, {2'b00, 28'h8000008});
    drain();

    // backpressure: 3 accepted, 4th offered while output stalls 5 cycles
    push(32'h3F800000);
    push(32'hBFC00000);
    push(32'h40000000);
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'h3E000000, 1'b0, 1'b0, '0);
    push(32'h3E000000);
    drain();

    // reset with three words in flight
    push(32'h3F000000);
    push(32'h3F400000);
    push(32'hBF400000);
    @(posedge clk);
    #2;
    bus.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_out", {bus.ovf, bus.nan, bus.fixed_out}, 0);
    exp_q.delete();
    stall_prev = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1, 1'b0, '0);
    push(32'h3F000000);
    drain();

    // randomized traffic with random backpressure
    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 9) < 7), rnd_word(), ($urandom_range(0, 3) != 0), 1'b0, '0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fp2fix_pipe.md
FP2FIX_PIPE -- requirements
Module: fp2fix_pipe

Interface
REQ-001 The block SHALL have no parameters; the fixed-point format is fixed at signed Q3.25 (28 bits: sign, 2 integer bits, 25 fraction bits).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-004 in_valid  input  1  dataa carries a word this cycle.
REQ-005 in_ready  output  1  block accepts dataa this cycle.
REQ-006 dataa  input  32  IEEE-754 single-precision operand (angle in radians) for the CORDIC stage.
REQ-007 out_valid  output  1  fixed_out/ovf/nan are valid.
REQ-008 out_ready  input  1  downstream CORDIC accepts the output this cycle.
REQ-009 fixed_out  output  28  two's-complement Q3.25 conversion result.
REQ-010 ovf  output  1  result was saturated (|x| >= 4.0 or infinity).
REQ-011 nan  output  1  operand was NaN.

Function
REQ-012 The pipeline SHALL have three register stages: S1 unpack/classify, S2 magnitude shift, S3 sign apply/saturate; latency is 3 cycles from an accepted input to out_valid, with no stalls.
REQ-013 The pipeline SHALL use a global advance = !out_valid | out_ready; all stages, including their valid bits, load only when advance = 1.
REQ-014 in_ready SHALL equal advance; a transfer occurs when in_valid & in_ready.
REQ-015 When advance = 1 and no transfer occurs, S1 SHALL load a bubble (valid = 0); bubbles are not collapsed.
REQ-016 While out_valid = 1 and out_ready = 0, fixed_out, ovf, nan and out_valid SHALL hold stable.
REQ-017 Throughput SHALL be one conversion per cycle while out_ready = 1.
REQ-018 Magnitude SHALL be m = {1, frac[22:0]} for a biased exponent e in 1..254, and the shift amount SHALL be k = e - 125.
REQ-019 For k in 0..3, the magnitude SHALL be m << k; for k < 0, it SHALL be m >> (125 - e), truncated toward zero; for 125 - e >= 24, it SHALL be 0.
REQ-020 For e >= 129 (k >= 4) with a finite operand, the result SHALL saturate to 0x7FFFFFF (positive) or 0x8000000 (negative), with ovf = 1.
REQ-021 For e = 0 (zero or denormal), the result SHALL be 0x0000000 with ovf = 0 and nan = 0; -0.0 also yields 0x0000000.
REQ-022 For e = 255 with frac = 0 (infinity), the result SHALL saturate by sign per REQ-020, with ovf = 1.
REQ-023 For e = 255 with frac != 0 (NaN), the result SHALL be 0x0000000 with nan = 1 and ovf = 0.
REQ-024 For a negative finite in-range operand, fixed_out SHALL be the two's complement of the 27-bit magnitude.
REQ-025 ovf and nan SHALL be registered alongside their data and SHALL be mutually exclusive.

Reset
REQ-026 While rst = 0, out_valid SHALL be 0, fixed_out SHALL be 0x0000000, and ovf and nan SHALL be 0.
REQ-027 All stage valid bits and data registers SHALL clear during reset, so that in-flight words are discarded.
REQ-028 in_ready SHALL be 1 from the first cycle after rst is released.
REQ-029 No output SHALL go valid until 3 cycles after the first post-reset transfer.

Verification
REQ-030 The bench SHALL cover basic conversion: 0x3F060A92, 0x3E860A92 and 0xBF060A92 on consecutive cycles with out_ready = 1 -> fixed_out 0x10C1524, 0x0860A92 and 0xEF3EADC on cycles 3, 4 and 5 after the first transfer, with ovf = nan = 0.
REQ-031 The bench SHALL cover special values: 0x40800000 (4.0) -> 0x7FFFFFF with ovf = 1; 0xFF800000 (-inf) -> 0x8000000 with ovf = 1; 0x7FC00000 -> 0x0000000 with nan = 1; 0x00000001 -> 0x0000000 with no flags.
REQ-032 The bench SHALL cover underflow: 0x33000000 (2^-25) -> 0x0000001; 0x32800000 (2^-26) -> 0x0000000.
REQ-033 The bench SHALL cover backpressure: stream 4 words and hold out_ready = 0 for 5 cycles after the first out_valid -> outputs stable, in_ready = 0 while stalled, no word lost or duplicated, and order preserved after release.
REQ-034 The bench SHALL cover reset mid-operation: assert rst = 0 with 3 words in flight -> out_valid = 0 and fixed_out = 0 immediately, and no stale word appears after release.
